// File: rtl/sd_cmd_resp_ctrl.sv
// SD CMD-line response receiver: waits for the start bit, counts the frame, checks CRC7
// and the end bit, then latches the deserialized response and reports one completion.
module sd_cmd_resp_ctrl #(
    parameter int BITS         = 136,
    parameter int BITS_COUNTER = 8,
    parameter int TIMEOUT      = 64,
    parameter int TIMEOUT_BITS = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    long_resp,
    input  logic                    check_crc,
    input  logic                    cmd_in,
    output logic                    des_enable,
    output logic [BITS_COUNTER-1:0] des_framesize,
    input  logic                    des_complete,
    input  logic [BITS-1:0]         des_data,
    output logic [BITS-1:0]         resp,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic                    crc_err,
    output logic                    end_err,
    output logic                    frame_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RECV, FINISH} state_t;

    localparam logic [BITS_COUNTER-1:0] SHORT_SIZE = BITS_COUNTER'(48);
    localparam logic [BITS_COUNTER-1:0] LONG_SIZE  = BITS_COUNTER'(136);

    state_t                  state;
    logic [BITS_COUNTER-1:0] bit_cnt;
    logic [TIMEOUT_BITS-1:0] tmo_cnt;
    logic [1:0]              fin_cnt;
    logic [6:0]              crc_calc;
    logic [6:0]              crc_rx;
    logic                    long_q;
    logic                    check_q;
    logic                    crc_bad;

    logic [BITS_COUNTER-1:0] crc_lo, crc_hi, rx_lo, rx_hi, last_idx;
    logic                    in_crc, in_rx, crc_fb;
    logic [6:0]              crc_next;

    // R2 frames cover the CID/CSD payload only; short frames cover everything after the start bit
    always_comb begin
        crc_lo   = long_q ? BITS_COUNTER'(8)   : BITS_COUNTER'(1);
        crc_hi   = long_q ? BITS_COUNTER'(127) : BITS_COUNTER'(39);
        rx_lo    = long_q ? BITS_COUNTER'(128) : BITS_COUNTER'(40);
        rx_hi    = long_q ? BITS_COUNTER'(134) : BITS_COUNTER'(46);
        last_idx = des_framesize - BITS_COUNTER'(1);
        in_crc   = (bit_cnt >= crc_lo) && (bit_cnt <= crc_hi);
        in_rx    = (bit_cnt >= rx_lo) && (bit_cnt <= rx_hi);
        crc_fb   = crc_calc[6] ^ cmd_in;
        crc_next = {crc_calc[5:3], crc_calc[2] ^ crc_fb, crc_calc[1:0], crc_fb};
    end

    always_comb begin
        des_enable = 1'b0;
        case (state)
            WAIT:           des_enable = ~cmd_in;
            RECV, FINISH:   des_enable = 1'b1;
            default:        des_enable = 1'b0;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            tmo_cnt       <= '0;
            fin_cnt       <= '0;
            crc_calc      <= '0;
            crc_rx        <= '0;
            long_q        <= 1'b0;
            check_q       <= 1'b0;
            crc_bad       <= 1'b0;
            des_framesize <= SHORT_SIZE;
            resp          <= '0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            crc_err       <= 1'b0;
            end_err       <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        timeout_err   <= 1'b0;
                        crc_err       <= 1'b0;
                        end_err       <= 1'b0;
                        frame_err     <= 1'b0;
                        long_q        <= long_resp;
                        check_q       <= check_crc;
                        des_framesize <= long_resp ? LONG_SIZE : SHORT_SIZE;
                        tmo_cnt       <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (!cmd_in) begin
                        bit_cnt  <= BITS_COUNTER'(1);
                        crc_calc <= '0;
                        crc_rx   <= '0;
                        state    <= RECV;
                    end else if (tmo_cnt == TIMEOUT_BITS'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_BITS'(1);
                    end
                end
                RECV: begin
                    bit_cnt <= bit_cnt + BITS_COUNTER'(1);
                    if (in_crc)
                        crc_calc <= crc_next;
                    if (in_rx)
                        crc_rx <= {crc_rx[5:0], cmd_in};
                    // Received CRC field is complete one bit before the end bit
                    if (bit_cnt == last_idx) begin
                        end_err <= ~cmd_in;
                        crc_bad <= (crc_calc != crc_rx);
                        fin_cnt <= '0;
                        state   <= FINISH;
                    end
                end
                FINISH: begin
                    if (des_complete) begin
                        resp    <= des_data;
                        crc_err <= check_q & crc_bad;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else if (fin_cnt == 2'd3) begin
                        frame_err <= 1'b1;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        fin_cnt <= fin_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
